packet_builder: RTL and testbench

Transmit-side counterpart of the packet parser. On a start pulse, captures Ethernet, IP and TCP headers. Streams them MSB-first as 32-bit words, then streams a fixed-length payload drained from a payload FIFO. Output uses the same valid/ready word protocol the parser consumes, so the two blocks can be connected back to back.

---
 rtl/packet_builder.sv | 189 ++++++++++++++++++
 tb/tb_packet_builder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_builder.sv
// Transmit-side packet builder: serialises Ethernet/IP/TCP headers MSB-first,
// then drains a fixed-length payload from a FIFO onto a valid/ready word stream.
module packet_builder #(
    parameter int DATA_W    = 32,
    parameter int ETH_WORDS = 4,
    parameter int IP_WORDS  = 5,
    parameter int TCP_WORDS = 5,
    parameter int PAY_WORDS = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ETH_WORDS*DATA_W-1:0]   eth_hdr,
    input  logic [IP_WORDS*DATA_W-1:0]    ip_hdr,
    input  logic [TCP_WORDS*DATA_W-1:0]   tcp_hdr,
    input  logic [DATA_W-1:0]             pay_fifo_data,
    input  logic                          pay_fifo_empty,
    output logic                          pay_fifo_rd_en,
    output logic [DATA_W-1:0]             data_out,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic                          last_out,
    output logic                          busy,
    output logic                          done
);

    localparam int ETH_BITS = ETH_WORDS * DATA_W;
    localparam int HDR_BITS = (ETH_WORDS + IP_WORDS + TCP_WORDS) * DATA_W;
    localparam int HDR_MAX  = (ETH_WORDS > IP_WORDS) ?
                              ((ETH_WORDS > TCP_WORDS) ? ETH_WORDS : TCP_WORDS) :
                              ((IP_WORDS > TCP_WORDS) ? IP_WORDS : TCP_WORDS);
    localparam int CNT_MAX  = (HDR_MAX > PAY_WORDS) ? HDR_MAX : PAY_WORDS;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ETH,
        IP,
        TCP,
        PAY,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [HDR_BITS-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [CNT_W-1:0]    sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic                rd_pend_q, rd_pend_d;

    logic                xfer;
    logic                sec_end;
    logic                rd_en_w;

    assign xfer = valid_q & ready_out;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            sec_cnt_q <= '0;
            rd_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            sec_cnt_q <= sec_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        sec_cnt_d = sec_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        rd_pend_d = rd_pend_q;
        sec_end   = 1'b0;

        case (state_q)
            ETH: sec_end = (sec_cnt_q == CNT_W'(ETH_WORDS - 1));
            IP:  sec_end = (sec_cnt_q == CNT_W'(IP_WORDS - 1));
            TCP: sec_end = (sec_cnt_q == CNT_W'(TCP_WORDS - 1));
            default: sec_end = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Word 0 goes straight to the output; the register keeps the rest.
                    hdr_d     = {eth_hdr, ip_hdr, tcp_hdr} << DATA_W;
                    data_d    = eth_hdr[ETH_BITS-1 -: DATA_W];
                    valid_d   = 1'b1;
                    last_d    = 1'b0;
                    sec_cnt_d = '0;
                    rd_cnt_d  = '0;
                    rd_pend_d = 1'b0;
                    state_d   = ETH;
                end
            end
            ETH, IP, TCP: begin
                if (xfer) begin
                    data_d = hdr_q[HDR_BITS-1 -: DATA_W];
                    hdr_d  = hdr_q << DATA_W;
                    if (sec_end) begin
                        sec_cnt_d = '0;
                        case (state_q)
                            ETH:     state_d = IP;
                            IP:      state_d = TCP;
                            default: begin
                                state_d = PAY;
                                valid_d = 1'b0;
                            end
                        endcase
                    end else begin
                        sec_cnt_d = sec_cnt_q + 1'b1;
                    end
                end
            end
            PAY: begin
                rd_pend_d = rd_en_w;
                if (rd_en_w) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (xfer) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = DONE;
                    end
                end
                // A pending read implies the output register was freed when it was issued.
                if (rd_pend_q) begin
                    data_d  = pay_fifo_data;
                    valid_d = 1'b1;
                    last_d  = (rd_cnt_q == CNT_W'(PAY_WORDS));
                end
            end
            DONE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        rd_en_w = 1'b0;
        case (state_q)
            ETH, IP, TCP: busy = 1'b1;
            PAY: begin
                busy    = 1'b1;
                rd_en_w = !rst && !rd_pend_q && (!valid_q || ready_out) &&
                          !pay_fifo_empty && (rd_cnt_q < CNT_W'(PAY_WORDS));
            end
            DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign pay_fifo_rd_en = rd_en_w;
    assign data_out       = data_q;
    assign valid_out      = valid_q;
    assign last_out       = last_q;

endmodule

// File: tb/tb_packet_builder.sv
// Directed/randomised bench for packet_builder with a queue-based FIFO model
// and an expected-word-stream reference built directly from header/payload values.
module tb_packet_builder;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] eth_hdr;
    logic [159:0] ip_hdr;
    logic [159:0] tcp_hdr;
    logic [31:0]  pay_fifo_data;
    logic         pay_fifo_empty;
    logic         pay_fifo_rd_en;
    logic [31:0]  data_out;
    logic         valid_out;
    logic         ready_out;
    logic         last_out;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    packet_builder #(
        .DATA_W   (32),
        .ETH_WORDS(4),
        .IP_WORDS (5),
        .TCP_WORDS(5),
        .PAY_WORDS(10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .eth_hdr       (eth_hdr),
        .ip_hdr        (ip_hdr),
        .tcp_hdr       (tcp_hdr),
        .pay_fifo_data (pay_fifo_data),
        .pay_fifo_empty(pay_fifo_empty),
        .pay_fifo_rd_en(pay_fifo_rd_en),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .ready_out     (ready_out),
        .last_out      (last_out),
        .busy          (busy),
        .done          (done)
    );

    // Payload FIFO model: one-cycle read latency
    logic [31:0] fmem [0:511];
    int          pushed = 0;
    int          popped = 0;
    int          rd_bad = 0;
    logic [31:0] fdata  = '0;

    assign pay_fifo_empty = (pushed == popped);
    assign pay_fifo_data  = fdata;

    always @(posedge clk) begin
        if (pay_fifo_rd_en) begin
            if (popped < pushed) begin
                fdata  <= fmem[popped];
                popped <= popped + 1;
            end else begin
                rd_bad <= rd_bad + 1;
            end
        end
    end

    // Stream monitor, sampled on the falling edge
    logic [32:0] rx_w [0:1023];
    int          rx_n      = 0;
    int          done_n    = 0;
    int          hold_viol = 0;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0, prst = 1'b0;
    logic [31:0] pd = '0;

    always @(negedge clk) begin
        if (valid_out && ready_out && !rst) begin
            rx_w[rx_n] <= {last_out, data_out};
            rx_n       <= rx_n + 1;
        end
        if (done && !rst) done_n <= done_n + 1;
        if (pv && !pr && !prst && (!valid_out || data_out !== pd || last_out !== pl))
            hold_viol <= hold_viol + 1;
        pv   <= valid_out;
        pr   <= ready_out;
        pd   <= data_out;
        pl   <= last_out;
        prst <= rst;
    end

    int          checks   = 0;
    int          failures = 0;
    int          cmp_n    = 0;
    logic [31:0] pay_q [$];
    logic [32:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hdr(input logic [447:0] h);
        eth_hdr = h[447:320];
        ip_hdr  = h[319:160];
        tcp_hdr = h[159:0];
    endtask

    function automatic logic [447:0] rand_hdr();
        logic [447:0] h;
        for (int i = 0; i < 14; i++) h[i*32 +: 32] = $urandom;
        return h;
    endfunction

    task automatic push_pay(input logic [31:0] w);
        fmem[pushed] = w;
        pushed++;
        pay_q.push_back(w);
    endtask

    // Expected stream: 14 header words MSB-first, then npay payload words, last on word 9
    task automatic expect_pkt(input logic [447:0] h, input int npay);
        logic [31:0] w;
        for (int i = 0; i < 14; i++) exp_q.push_back({1'b0, h[447-32*i -: 32]});
        for (int j = 0; j < npay; j++) begin
            w = pay_q.pop_front();
            exp_q.push_back({(j == 9), w});
        end
    endtask

    task automatic compare_stream(input string tag);
        logic [32:0] e;
        check({tag, "_count"}, rx_n, cmp_n + exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_word"}, rx_w[cmp_n], e);
            cmp_n++;
        end
        cmp_n = rx_n;
    endtask

    task automatic start_pkt();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rx_n < n; i++) tick();
        check(tag, rx_n >= n, 1);
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (rnd) ready_out = 1'($urandom_range(0, 1));
            tick();
            if (done) seen = 1'b1;
        end
        ready_out = 1'b1;
        check(tag, seen, 1);
    endtask

    initial begin
        logic [447:0] h, h2;
        int           d0, base;
        bit           exp_valid, exp_rd;

        rst       = 1'b1;
        start     = 1'b0;
        ready_out = 1'b1;
        set_hdr('0);
        tick();
        tick();
        check("rst_data", data_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_last", last_out, 0);
        check("rst_rd_en", pay_fifo_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Nominal packet with cycle-exact timing
        h = {{16{8'hA1}}, {20{8'hB2}}, {20{8'hC3}}};
        set_hdr(h);
        for (int j = 0; j < 10; j++) push_pay(32'hD4F40099);
        d0 = done_n;
        start_pkt();
        check("nom_word0", data_out, 32'hA1A1A1A1);
        for (int k = 1; k <= 37; k++) begin
            if (k > 1) tick();
            exp_valid = (k <= 14) || (k >= 17 && k <= 35 && ((k - 17) % 2 == 0));
            exp_rd    = (k >= 15 && k <= 33 && ((k - 15) % 2 == 0));
            check("nom_valid", valid_out, exp_valid);
            check("nom_rd_en", pay_fifo_rd_en, exp_rd);
            check("nom_done", done, k == 36);
            check("nom_busy", busy, k <= 35);
            check("nom_last", last_out, k == 35);
        end
        expect_pkt(h, 10);
        compare_stream("nom");
        check("nom_done_count", done_n, d0 + 1);

        // Backpressure on word 1
        h = rand_hdr();
        h[447:384] = 64'h8F3A9C12_7BD4E6A0;
        set_hdr(h);
        for (int j = 0; j < 10; j++) push_pay($urandom);
        start_pkt();
        check("bp_word0", data_out, 32'h8F3A9C12);
        tick();
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_data", data_out, 32'h7BD4E6A0);
            check("bp_hold_valid", valid_out, 1);
            tick();
        end
        check("bp_after_data", data_out, 32'h7BD4E6A0);
        ready_out = 1'b1;
        wait_done("bp_done", 200, 1'b0);
        expect_pkt(h, 10);
        compare_stream("bp");

        // FIFO underrun after 4 payload words
        tick();
        h = rand_hdr();
        set_hdr(h);
        for (int j = 0; j < 4; j++) push_pay((j % 2 == 0) ? 32'h01234567 : 32'h89ABCDEF);
        base = rx_n;
        start_pkt();
        wait_rx("ur_wait", base + 18, 200);
        for (int i = 0; i < 20; i++) begin
            check("ur_valid", valid_out, 0);
            check("ur_rd_en", pay_fifo_rd_en, 0);
            check("ur_busy", busy, 1);
            tick();
        end
        for (int j = 4; j < 10; j++) push_pay((j % 2 == 0) ? 32'h01234567 : 32'h89ABCDEF);
        wait_done("ur_done", 200, 1'b0);
        expect_pkt(h, 10);
        compare_stream("ur");

        // Start while busy and start in the done cycle are both ignored
        tick();
        h  = rand_hdr();
        h2 = rand_hdr();
        set_hdr(h);
        for (int j = 0; j < 10; j++) push_pay($urandom);
        d0 = done_n;
        start_pkt();
        for (int i = 0; i < 5; i++) tick();
        set_hdr(h2);
        start_pkt();
        wait_done("sb_done", 200, 1'b0);
        start_pkt();
        check("sb_done_start_busy", busy, 0);
        for (int i = 0; i < 30; i++) tick();
        expect_pkt(h, 10);
        compare_stream("sb");
        check("sb_idle_busy", busy, 0);
        check("sb_done_count", done_n, d0 + 1);

        // Reset mid-payload, then a fresh packet
        h = rand_hdr();
        set_hdr(h);
        for (int j = 0; j < 4; j++) push_pay($urandom);
        d0   = done_n;
        base = rx_n;
        start_pkt();
        wait_rx("rs_wait", base + 18, 200);
        rst = 1'b1;
        tick();
        check("rs_valid", valid_out, 0);
        check("rs_busy", busy, 0);
        check("rs_done", done, 0);
        check("rs_rd_en", pay_fifo_rd_en, 0);
        rst = 1'b0;
        tick();
        check("rs_no_done", done_n, d0);
        expect_pkt(h, 4);
        compare_stream("rs_abort");
        h = rand_hdr();
        set_hdr(h);
        for (int j = 0; j < 10; j++) push_pay($urandom);
        start_pkt();
        check("rs_fresh_word0", data_out, h[447:416]);
        wait_done("rs_fresh_done", 200, 1'b0);
        expect_pkt(h, 10);
        compare_stream("rs_fresh");

        // Three back-to-back packets
        for (int p = 0; p < 3; p++) begin
            tick();
            h = rand_hdr();
            set_hdr(h);
            for (int j = 0; j < 10; j++) push_pay($urandom);
            start_pkt();
            wait_done("lb_done", 200, 1'b0);
            expect_pkt(h, 10);
        end
        compare_stream("lb");

        // Random backpressure
        tick();
        h = rand_hdr();
        set_hdr(h);
        for (int j = 0; j < 10; j++) push_pay($urandom);
        start_pkt();
        wait_done("rr_done", 500, 1'b1);
        expect_pkt(h, 10);
        compare_stream("rr");

        tick();
        check("hold_stable", hold_viol, 0);
        check("fifo_underflow", rd_bad, 0);
        check("fifo_drained", popped, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
